// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the two byte requesters, the scheduler and uart_tx.
// The slave side is the scheduler; the master side is everything around it.
interface uart_tx_sched_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in0_valid;
    logic [7:0]    in0_data;
    logic          in0_ready;
    logic          in1_valid;
    logic [7:0]    in1_data;
    logic          in1_ready;
    logic          tx_start;
    logic [7:0]    tx_bus;
    logic          tx_ready;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic          last_grant;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, tx_ready,
        output in0_ready, in1_ready, tx_start, tx_bus, fifo_count, busy, last_grant
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, tx_ready,
        input  in0_ready, in1_ready, tx_start, tx_bus, fifo_count, busy, last_grant
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-port byte arbiter feeding a shared FIFO that is drained one byte at a time into uart_tx.
// Contention alternates between ports; the drain FSM paces on tx_ready with a busy-rise timeout.
module uart_tx_sched #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        r_state, w_state_nx;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_timer, w_timer_nx;
    logic          r_tx_start, r_last_grant;
    logic [7:0]    r_tx_bus, w_wdata;
    logic          w_full, w_both, w_rdy0, w_rdy1, w_push, w_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_both  = bus.in0_valid && bus.in1_valid;
        w_rdy0  = !w_full && (!w_both || r_last_grant);
        w_rdy1  = !w_full && (!w_both || !r_last_grant);
        w_push  = (bus.in0_valid && w_rdy0) || (bus.in1_valid && w_rdy1);
        w_wdata = (bus.in0_valid && w_rdy0) ? bus.in0_data : bus.in1_data;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:      if (r_count != '0 && bus.tx_ready) w_state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!bus.tx_ready)                               w_state_nx = WAIT_DONE;
                else if (r_timer == TW'(BUSY_TIMEOUT - 1))       w_state_nx = IDLE;
            end
            WAIT_DONE: if (bus.tx_ready) w_state_nx = IDLE;
            default:   w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_timer_nx = r_timer;
        case (r_state)
            IDLE: begin
                w_pop      = (r_count != '0) && bus.tx_ready;
                w_timer_nx = '0;
            end
            WAIT_BUSY: begin
                if (bus.tx_ready && r_timer != TW'(BUSY_TIMEOUT - 1)) w_timer_nx = r_timer + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_bus   <= 8'h00;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_tx_start <= w_pop;
            r_timer    <= w_timer_nx;
            if (w_pop) r_tx_bus <= r_mem[r_rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_both && w_push) r_last_grant <= !r_last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) r_mem[r_wptr] <= w_wdata;
    end

    assign bus.in0_ready  = w_rdy0;
    assign bus.in1_ready  = w_rdy1;
    assign bus.tx_start   = r_tx_start;
    assign bus.tx_bus     = r_tx_bus;
    assign bus.fifo_count = r_count;
    assign bus.busy       = (r_state != IDLE) || (r_count != '0);
    assign bus.last_grant = r_last_grant;
endmodule
